// File: rtl/dl11_serial_core.sv
// DL11 console serial core: baud-rate generator plus 8N1 UART transmitter
// and receiver. The baud "clocks" are single-cycle enables derived from clk,
// so the whole block lives in one clock domain. The register front-end uses
// ld_tx_data / uld_rx_data to hand bytes in and out.
module dl11_serial_core #(
  parameter int RX_DIV  = 326,  // clk cycles per 16x receive tick
  parameter int OVERSMP = 16    // receive ticks per bit time
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_tx_data,
  input  logic [7:0] tx_data,
  input  logic       tx_enable,
  output logic       tx_out,
  output logic       tx_empty,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  input  logic       rx_enable,
  input  logic       rx_in,
  output logic       rx_empty
);

  localparam int DIV_W = (RX_DIV  > 1) ? $clog2(RX_DIV)  : 1;
  localparam int OS_W  = (OVERSMP > 1) ? $clog2(OVERSMP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RX_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSMP - 1);
  // Last tick of the half-bit wait that centres sampling on each bit.
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSMP / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------------------------------------------------------------------
  // Baud-rate generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q,  os_cnt_d;
  logic             rx_tick;
  logic             tx_tick;

  assign rx_tick = (div_cnt_q == DIV_LAST);
  assign tx_tick = rx_tick && (os_cnt_q == OS_LAST);

  // Divide clk down to the 16x tick, then count ticks to form the 1x tick.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    div_cnt_d = div_cnt_q + DIV_W'(1);
    os_cnt_d  = os_cnt_q;
    if (rx_tick) begin
      div_cnt_d = '0;
      os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  // Baud counter registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q,   tx_bit_d;
  logic       tx_out_q,   tx_out_d;
  logic       tx_empty_q, tx_empty_d;

  assign tx_out   = tx_out_q;
  assign tx_empty = tx_empty_q;

  // Transmit FSM: accept one byte while idle, then shift start, 8 data bits
  // (LSB first) and stop, each held for one tx_tick period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_out_d   = tx_out_q;
    tx_empty_d = tx_empty_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_empty_q) begin
          // A held ld_tx_data loads only once: tx_empty drops immediately.
          if (ld_tx_data && tx_enable) begin
            tx_shift_d = tx_data;
            tx_empty_d = 1'b0;
          end
        end else if (tx_tick) begin
          tx_state_d = TX_START;
          tx_out_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_out_d   = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = TX_IDLE;
          tx_empty_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Transmit state registers; line returns high on the edge that sees reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_out_q   <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_out_q   <= tx_out_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            rx_sync1_q, rx_sync2_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [OS_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]      rx_bit_q,   rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q,  rx_data_d;
  logic            rx_empty_q, rx_empty_d;

  assign rx_data  = rx_data_q;
  assign rx_empty = rx_empty_q;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      rx_sync1_q <= rx_in;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  // Receive FSM: find the start edge, qualify it at mid-bit, then sample
  // data and stop bits every OVERSMP ticks. A completed byte overrides a
  // same-cycle unload so the new byte is never lost.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_empty_d = rx_empty_q;

    if (uld_rx_data) rx_empty_d = 1'b1;

    if (!rx_enable) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      rx_bit_d   = '0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_tick && !rx_sync2_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_cnt_q == OS_MID) begin
              rx_cnt_d   = '0;
              rx_bit_d   = '0;
              rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt_d = rx_cnt_q + OS_W'(1);
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            if (rx_cnt_q == OS_LAST) begin
              rx_cnt_d   = '0;
              rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
              if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
              else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
              rx_cnt_d = rx_cnt_q + OS_W'(1);
            end
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            if (rx_cnt_q == OS_LAST) begin
              rx_cnt_d   = '0;
              rx_state_d = RX_IDLE;
              // A low stop bit is a framing error: the byte is dropped.
              if (rx_sync2_q) begin
                rx_data_d  = rx_shift_q;
                rx_empty_d = 1'b0;
              end
            end else begin
              rx_cnt_d = rx_cnt_q + OS_W'(1);
            end
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Receive state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_empty_q <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_empty_q <= rx_empty_d;
    end
  end

endmodule

// File: tb/tb_dl11_serial_core.sv
// Bench for dl11_serial_core with RX_DIV=4 (one bit = 64 clk). Stimulus pushes
// expected frames/bytes into queues; two monitors decode tx_out and watch the
// receive outputs, popping and comparing independently of the stimulus.
module tb_dl11_serial_core;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_enable = 1'b1;
  logic       tx_out;
  logic       tx_empty;
  logic       uld_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic       rx_enable = 1'b1;
  logic       rx_in;
  logic       rx_empty;

  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_mon_en = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  assign rx_in = loop_en ? tx_out : rx_drv;

  dl11_serial_core #(.RX_DIV(4), .OVERSMP(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_enable   (tx_enable),
    .tx_out      (tx_out),
    .tx_empty    (tx_empty),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .rx_empty    (rx_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tx_empty(input logic val, input int budget, input string name);
    int n = 0;
    while (tx_empty !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_empty), 32'(val));
  endtask

  task automatic wait_rx_empty(input logic val, input int budget, input string name);
    int n = 0;
    while (rx_empty !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_empty), 32'(val));
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data    = b;
    ld_tx_data = 1'b1;
    @(negedge clk);
    ld_tx_data = 1'b0;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Transmit monitor: on a falling line, sample each of the 10 bits mid-bit.
  initial begin
    logic       prev = 1'b1;
    logic [9:0] bits;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !reset && prev && !tx_out) begin
        repeat (BIT_CLK / 2) @(negedge clk);
        bits[0] = tx_out;
        for (int i = 1; i < 10; i++) begin
          repeat (BIT_CLK) @(negedge clk);
          bits[i] = tx_out;
        end
        if (tx_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tx_unexpected_frame: got line bits 0x%03h, expected idle line", bits);
        end else begin
          e = tx_q.pop_front();
          check("tx_frame_bits", 32'(bits), 32'({1'b1, e, 1'b0}));
        end
      end
      prev = tx_out;
    end
  end

  // Receive monitor: a new byte is rx_empty falling, or rx_data changing
  // while rx_empty stays low (overrun).
  initial begin
    logic       pe = 1'b1;
    logic [7:0] pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && !rx_empty && (pe || rx_data !== pd)) begin
        if (rx_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rx_unexpected_byte: got 0x%02h, expected no byte", rx_data);
        end else begin
          check("rx_byte", 32'(rx_data), 32'(rx_q.pop_front()));
        end
      end
      pe = rx_empty;
      pd = rx_data;
    end
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_tx_out",   32'(tx_out),   32'd1);
    check("reset_tx_empty", 32'(tx_empty), 32'd1);
    check("reset_rx_empty", 32'(rx_empty), 32'd1);
    check("reset_rx_data",  32'(rx_data),  32'h00);
    repeat (10) @(negedge clk);

    // Hold ld_tx_data with 8'hA5: exactly one frame.
    tx_q.push_back(8'hA5);
    tx_data    = 8'hA5;
    ld_tx_data = 1'b1;
    @(negedge clk);
    check("tx_empty_falls_on_load", 32'(tx_empty), 32'd0);
    check("tx_line_idle_before_tick", 32'(tx_out), 32'd1);
    n = 1;
    repeat (149) begin
      @(negedge clk);
      n++;
    end
    check("tx_busy_with_ld_held", 32'(tx_empty), 32'd0);
    ld_tx_data = 1'b0;
    while (tx_empty !== 1'b1 && n < 900) begin
      @(negedge clk);
      n++;
    end
    check("tx_frame_length_641_to_704", 32'(n >= 641 && n <= 704), 32'd1);
    repeat (200) @(negedge clk);
    check("tx_single_frame_empty", 32'(tx_empty), 32'd1);
    check("tx_single_frame_line",  32'(tx_out),   32'd1);

    // Loopback 8'h3C.
    loop_en = 1'b1;
    tx_q.push_back(8'h3C);
    rx_q.push_back(8'h3C);
    load_tx(8'h3C);
    wait_rx_empty(1'b0, 900, "rx_loop_byte_ready");
    wait_tx_empty(1'b1, 200, "tx_loop_done");
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check("rx_empty_after_unload", 32'(rx_empty), 32'd1);
    check("rx_data_kept_after_unload", 32'(rx_data), 32'h3C);
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // Short low pulse: false start.
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("rx_false_start_ignored", 32'(rx_empty), 32'd1);

    // Framing error: 8'h55 with stop bit 0.
    send_serial(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    check("rx_framing_error_dropped", 32'(rx_empty), 32'd1);
    check("rx_framing_error_data", 32'(rx_data), 32'h3C);

    // Overrun: 8'h11 then 8'h22 without unload.
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    send_serial(8'h11, 1'b1);
    send_serial(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_overrun_data",  32'(rx_data),  32'h22);
    check("rx_overrun_empty", 32'(rx_empty), 32'd0);
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check("rx_empty_after_overrun_unload", 32'(rx_empty), 32'd1);

    // Receiver disabled: frame ignored.
    rx_enable = 1'b0;
    send_serial(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    rx_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("rx_disabled_no_byte", 32'(rx_empty), 32'd1);

    // Reset in the middle of a transmit frame.
    tx_mon_en = 1'b0;
    load_tx(8'h00);
    n = 0;
    while (tx_out !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_bit_seen", 32'(tx_out), 32'd0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_tx_out",   32'(tx_out),   32'd1);
    check("midframe_reset_tx_empty", 32'(tx_empty), 32'd1);
    check("midframe_reset_rx_data",  32'(rx_data),  32'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tx_mon_en = 1'b1;

    // tx_enable low during load: nothing starts.
    tx_enable  = 1'b0;
    tx_data    = 8'h81;
    ld_tx_data = 1'b1;
    repeat (200) @(negedge clk);
    check("tx_disabled_empty", 32'(tx_empty), 32'd1);
    check("tx_disabled_line",  32'(tx_out),   32'd1);
    ld_tx_data = 1'b0;
    @(negedge clk);
    tx_enable = 1'b1;
    @(negedge clk);

    // Normal frame after re-enabling.
    tx_q.push_back(8'h81);
    load_tx(8'h81);
    check("tx_empty_falls_reenabled", 32'(tx_empty), 32'd0);
    wait_tx_empty(1'b1, 800, "tx_done_reenabled");

    repeat (100) @(negedge clk);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
